if_fetch_stage: RTL

- Instruction-fetch stage of the MIPS pipeline.
- Holds the PC and issues word fetches to instruction memory, which has variable latency and at most one request outstanding.
- Presents the fetched 32-bit word plus its PC as an IF/ID register that drives the instruction-split decode stage directly.
- Absorbs decode stalls with a one-entry skid buffer and handles branch/jump redirects, including squashing an in-flight fetch.

---
 rtl/if_fetch_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the MIPS pipeline. Holds the PC, issues one word
//   fetch at a time to a variable-latency instruction memory, and presents the
//   returned word with its PC as the IF/ID register feeding decode. A one-entry
//   skid buffer absorbs a response that returns while decode is stalled, and
//   branch/jump redirects flush IF/ID and squash any fetch still in flight.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   imem_req/imem_addr  : fetch request strobe and word-aligned byte address
//   imem_rvalid/rdata   : fetch response strobe and instruction word
//   stall               : decode cannot accept; IF/ID holds
//   redirect/redirect_pc: taken branch/jump and its target
//   instruction/instr_pc/instr_valid : IF/ID register outputs
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h00000000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;

  logic        accept;
  logic        hold;

  // A response is only consumed in WAIT; strobes in any other state are
  // protocol errors and are ignored. A set drop flag marks the in-flight
  // response as belonging to a squashed fetch.
  assign accept = (state_q == S_WAIT) && imem_rvalid && !drop_q;
  assign hold   = stall && instr_valid_q;

  // The request strobe is masked during reset so nothing is issued while the
  // state register is still being initialised.
  assign imem_req    = (state_q == S_REQ) && !reset;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    skid_vld_d    = skid_vld_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    if (redirect) begin
      // Redirect outranks stall: IF/ID and the skid buffer flush unconditionally.
      pc_d          = {redirect_pc[31:2], 2'b00};
      instr_valid_d = 1'b0;
      skid_vld_d    = 1'b0;
      drop_d        = 1'b0;
      case (state_q)
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        // The request going out this cycle is for the old pc; squash its reply.
        S_REQ: begin
          drop_d  = 1'b1;
          state_d = S_WAIT;
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      if (hold) begin
        instr_valid_d = 1'b1;
      end else if (skid_vld_q) begin
        instr_d       = skid_instr_q;
        instr_pc_d    = skid_pc_q;
        instr_valid_d = 1'b1;
      end else if (accept) begin
        instr_d       = imem_rdata;
        instr_pc_d    = pc_q;
        instr_valid_d = 1'b1;
      end else begin
        instr_valid_d = 1'b0;
      end

      case (state_q)
        S_REQ: state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              pc_d = pc_q + PC_STEP;
              if (hold) begin
                skid_instr_d = imem_rdata;
                skid_pc_d    = pc_q;
                skid_vld_d   = 1'b1;
                state_d      = S_FULL;
              end else begin
                state_d = S_REQ;
              end
            end
          end
        end
        S_FULL: begin
          if (!stall) begin
            skid_vld_d = 1'b0;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_REQ;
      pc_q          <= PC_RESET;
      drop_q        <= 1'b0;
      skid_vld_q    <= 1'b0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      skid_vld_q    <= skid_vld_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Skid payload is qualified by skid_vld_q and needs no reset.
  always_ff @(posedge clk) begin
    skid_instr_q <= skid_instr_d;
    skid_pc_q    <= skid_pc_d;
  end

endmodule
